// File: rtl/fp_special_resolve_pipe.sv
// Two-stage IEEE-754 special-operand resolver for add/sub/mul/div results, with a valid/ready stream on both sides.
// Optional invalid-result counter enabled by defining FP_EXC_CNT_EN; otherwise exc_cnt is tied to zero.
module fp_special_resolve_pipe #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    parameter  int CNT_W = 16,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     ans,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     s,
    output logic [3:0]       flags,
    input  logic             flag_clr,
    output logic [3:0]       flags_sticky,
    output logic [CNT_W-1:0] exc_cnt
);

    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_e;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } cls_t;

    localparam logic [W-1:0]     QN      = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-2:0]     INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic cls_t classify(input logic [W-1:0] x);
        cls_t c;
        logic exp_ones, exp_zero, man_nz;
        exp_ones = &x[W-2:MAN_W];
        exp_zero = ~|x[W-2:MAN_W];
        man_nz   = |x[MAN_W-1:0];
        c.nan    = exp_ones & man_nz;
        c.inf    = exp_ones & ~man_nz;
        c.zero   = exp_zero;
        return c;
    endfunction

    // Stage 1: operands, core result and operand classes.
    logic         v1;
    op_e          op1;
    logic [W-1:0] a1, b1, ans1;
    cls_t         ca1, cb1;

    // Stage 2: resolved result and its flags.
    logic         v2;
    logic [W-1:0] s2;
    logic [3:0]   flags2;

    logic         load2, load1, out_xfer;

    assign load2     = !v2 || out_ready;
    assign load1     = !v1 || load2;
    assign in_ready  = !v1 || !v2 || out_ready;
    assign out_xfer  = v2 && out_ready;
    assign out_valid = v2;
    assign s         = s2;
    assign flags     = flags2;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: datapath registers are reset too so s and flags read zero out of reset.
        if (rst) begin
            v1   <= 1'b0;
            op1  <= OP_ADD;
            a1   <= '0;
            b1   <= '0;
            ans1 <= '0;
            ca1  <= '0;
            cb1  <= '0;
        end else if (load1) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            v1 <= in_valid;
            if (in_valid) begin
                op1  <= op_e'(op);
                a1   <= a;
                b1   <= b;
                ans1 <= ans;
                ca1  <= classify(a);
                cb1  <= classify(b);
            end
        end
    end

    logic [W-1:0] res_s;
    logic         nan_in, invalid, divzero, special;
    logic         sa, sb_eff, sx;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        res_s   = ans1;
        nan_in  = 1'b0;
        invalid = 1'b0;
        divzero = 1'b0;
        special = 1'b1;
        sa      = a1[W-1];
        sb_eff  = b1[W-1] ^ (op1 == OP_SUB);
        sx      = a1[W-1] ^ b1[W-1];

        if (ca1.nan || cb1.nan) begin
            res_s  = QN;
            nan_in = 1'b1;
        end else begin
            unique case (op1)
                OP_ADD, OP_SUB: begin
                    if (ca1.inf && cb1.inf && (sa != sb_eff)) begin
                        res_s   = QN;
                        invalid = 1'b1;
                    end else if (ca1.inf)              res_s = {sa, INF_MAG};
                    else if (cb1.inf)                  res_s = {sb_eff, INF_MAG};
                    else if (ca1.zero && cb1.zero)     res_s = {sa & sb_eff, {(W-1){1'b0}}};
                    else if (ca1.zero)                 res_s = {sb_eff, b1[W-2:0]};
                    else if (cb1.zero)                 res_s = a1;
                    else                               special = 1'b0;
                end
                OP_MUL: begin
                    if ((ca1.inf && cb1.zero) || (ca1.zero && cb1.inf)) begin
                        res_s   = QN;
                        invalid = 1'b1;
                    end else if (ca1.inf || cb1.inf)   res_s = {sx, INF_MAG};
                    else if (ca1.zero || cb1.zero)     res_s = {sx, {(W-1){1'b0}}};
                    else                               special = 1'b0;
                end
                OP_DIV: begin
                    if ((ca1.zero && cb1.zero) || (ca1.inf && cb1.inf)) begin
                        res_s   = QN;
                        invalid = 1'b1;
                    end else if (cb1.zero && !ca1.inf) begin
                        res_s   = {sx, INF_MAG};
                        divzero = 1'b1;
                    end else if (ca1.inf || cb1.zero)  res_s = {sx, INF_MAG};
                    else if (ca1.zero || cb1.inf)      res_s = {sx, {(W-1){1'b0}}};
                    else                               special = 1'b0;
                end
                default: special = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2     <= 1'b0;
            s2     <= '0;
            flags2 <= '0;
        end else if (load2) begin
            v2 <= v1;
            if (v1) begin
                s2     <= res_s;
                flags2 <= {nan_in, invalid, divzero, special};
            end
        end
    end

    // A transfer's flags survive a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           flags_sticky <= '0;
        else if (out_xfer) flags_sticky <= (flag_clr ? 4'b0000 : flags_sticky) | flags2;
        else if (flag_clr) flags_sticky <= '0;
    end

`ifdef FP_EXC_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       cnt <= '0;
        else if (out_xfer && flags2[2]) begin
            if (flag_clr)              cnt <= CNT_ONE;
            else if (!(&cnt))          cnt <= cnt + CNT_ONE;
        end else if (flag_clr)         cnt <= '0;
    end

    assign exc_cnt = cnt;
`else
    assign exc_cnt = '0;
`endif

endmodule

// File: tb/tb_fp_special_resolve_pipe.sv
// Self-checking bench for fp_special_resolve_pipe: directed IEEE special cases, backpressure,
// randomized traffic against a class-table reference model, and mid-stream reset.
module tb_fp_special_resolve_pipe;

    localparam int W     = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready, flag_clr;
    logic [1:0]       op;
    logic [W-1:0]     a, b, ans, s;
    logic [3:0]       flags, flags_sticky;
    logic [CNT_W-1:0] exc_cnt;

    fp_special_resolve_pipe #(.EXP_W(8), .MAN_W(23), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .ans(ans), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .flags(flags), .flag_clr(flag_clr), .flags_sticky(flags_sticky),
        .exc_cnt(exc_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [35:0] q[$];
    logic [3:0]  sticky_m = '0;
    int          cnt_m = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: operand categories combined through the IEEE special-case tables.
    typedef enum {C_ZERO, C_FIN, C_INF, C_NAN} cat_e;

    function automatic cat_e cat_of(input logic [31:0] x);
        if (x[30:23] == 8'hFF) return (x[22:0] != 0) ? C_NAN : C_INF;
        if (x[30:23] == 8'h00) return C_ZERO;
        return C_FIN;
    endfunction

    function automatic logic [35:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y, input logic [31:0] r);
        cat_e        cx, cy;
        logic        sx, sy, sp;
        logic [31:0] qn, inf_p, zero_p;
        cx = cat_of(x);
        cy = cat_of(y);
        sx = x[31];
        sy = (o == 2'd1) ? ~y[31] : y[31];
        sp = x[31] ^ y[31];
        qn = 32'h7FFF_FFFF;
        inf_p  = {sp, 31'h7F80_0000};
        zero_p = {sp, 31'h0};
        if (cx == C_NAN || cy == C_NAN) return {qn, 4'b1001};
        if (o <= 2'd1) begin
            if (cx == C_INF && cy == C_INF) return (sx != sy) ? {qn, 4'b0101} : {sx, 31'h7F80_0000, 4'b0001};
            if (cx == C_INF)                return {sx, 31'h7F80_0000, 4'b0001};
            if (cy == C_INF)                return {sy, 31'h7F80_0000, 4'b0001};
            if (cx == C_ZERO && cy == C_ZERO) return {sx & sy, 31'h0, 4'b0001};
            if (cx == C_ZERO)               return {sy, y[30:0], 4'b0001};
            if (cy == C_ZERO)               return {x, 4'b0001};
            return {r, 4'b0000};
        end
        if (o == 2'd2) begin
            if ((cx == C_INF && cy == C_ZERO) || (cx == C_ZERO && cy == C_INF)) return {qn, 4'b0101};
            if (cx == C_INF || cy == C_INF)   return {inf_p, 4'b0001};
            if (cx == C_ZERO || cy == C_ZERO) return {zero_p, 4'b0001};
            return {r, 4'b0000};
        end
        if (cx == cy && (cx == C_ZERO || cx == C_INF)) return {qn, 4'b0101};
        if (cx == C_FIN && cy == C_ZERO)               return {inf_p, 4'b0011};
        if (cx == C_INF)                               return {inf_p, 4'b0001};
        if (cx == C_ZERO || cy == C_INF)               return {zero_p, 4'b0001};
        return {r, 4'b0000};
    endfunction

    // One clock: score any transfers, update sticky/counter model, check sticky/counter.
    task automatic tick();
        logic        xi, xo;
        logic [35:0] pend, e;
        #1;
        xi = in_valid && in_ready;
        xo = out_valid && out_ready;
        pend = '0;
        if (xi) pend = ref_model(op, a, b, ans);
        if (xo) begin
            if (q.size() == 0) begin
                check("spurious_out", out_valid, 1'b0);
            end else begin
                e = q.pop_front();
                check("s", s, e[35:4]);
                check("flags", flags, e[3:0]);
                sticky_m = (flag_clr ? 4'b0 : sticky_m) | e[3:0];
                if (e[2])          cnt_m = flag_clr ? 1 : ((cnt_m == 65535) ? cnt_m : cnt_m + 1);
                else if (flag_clr) cnt_m = 0;
            end
        end else if (flag_clr) begin
            sticky_m = '0;
            cnt_m    = 0;
        end
        @(posedge clk);
        #1;
        if (xi) q.push_back(pend);
        check("sticky", flags_sticky, sticky_m);
`ifdef FP_EXC_CNT_EN
        check("exc_cnt", exc_cnt, cnt_m);
`else
        check("exc_cnt", exc_cnt, 0);
`endif
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("drain", q.size(), 0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] pool [9];
        pool = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
                 32'hFFC0_0001, 32'h0000_0001, 32'h3F80_0000, 32'hC040_0000};
        if ($urandom_range(0, 2) == 0) return $urandom();
        return pool[$urandom_range(0, 8)];
    endfunction

    logic [1:0]  d_op  [8];
    logic [31:0] d_a   [8];
    logic [31:0] d_b   [8];
    logic [31:0] d_ans [8];
    int          accepted;
    int          idx;

    initial begin
        d_op  = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2};
        d_a   = '{32'h7F80_0000, 32'h7F80_0000, 32'h3F80_0000, 32'h8000_0000,
                  32'h0000_0000, 32'h7FC0_0001, 32'h3F80_0000, 32'hC000_0000};
        d_b   = '{32'hFF80_0000, 32'hFF80_0000, 32'h8000_0000, 32'h8000_0000,
                  32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0000};
        d_ans = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
                  32'h1234_5678, 32'h1234_5678, 32'h4040_0000, 32'h1234_5678};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
        op = 2'd0; a = '0; b = '0; ans = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_s", s, 32'h0);
        check("rst_flags", flags, 4'h0);
        check("rst_sticky", flags_sticky, 4'h0);
        check("rst_exc_cnt", exc_cnt, 0);
        check("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;

        // Latency: mul Inf*0 appears exactly two edges after acceptance.
        in_valid = 1'b1; op = 2'd2; a = 32'h7F80_0000; b = 32'h0; ans = 32'hDEAD_BEEF;
        tick();
        in_valid = 1'b0;
        check("lat_1cyc_valid", out_valid, 1'b0);
        tick();
        check("lat_2cyc_valid", out_valid, 1'b1);
        check("lat_s", s, 32'h7FFF_FFFF);
        check("lat_flags", flags, 4'b0101);
        drain();

        // Directed special cases, back to back.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; op = d_op[i]; a = d_a[i]; b = d_b[i]; ans = d_ans[i];
            tick();
        end
        drain();

        // Backpressure: 6 stalled cycles with continuous input offers.
        out_ready = 1'b0;
        accepted  = 0;
        idx       = 0;
        in_valid  = 1'b1; op = d_op[0]; a = d_a[0]; b = d_b[0]; ans = d_ans[0];
        repeat (6) begin
            #1;
            if (in_ready) accepted++;
            tick();
            if (accepted > idx) begin
                idx = accepted;
                op = d_op[idx]; a = d_a[idx]; b = d_b[idx]; ans = d_ans[idx];
            end
        end
        check("bp_accepted", accepted, 2);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_hold_s", s, 32'h7FFF_FFFF);
        out_ready = 1'b1;
        while (idx < 4) begin
            #1;
            if (in_ready) idx++;
            tick();
            if (idx < 4) begin
                op = d_op[idx]; a = d_a[idx]; b = d_b[idx]; ans = d_ans[idx];
            end
        end
        drain();

        // Randomized traffic with random backpressure and occasional clears.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flag_clr  = ($urandom_range(0, 15) == 0);
            op  = 2'($urandom_range(0, 3));
            a   = pick_operand();
            b   = pick_operand();
            ans = $urandom();
            tick();
        end
        flag_clr = 1'b0;
        drain();

        // Reset mid-stream with a held output.
        in_valid = 1'b1; out_ready = 1'b0; op = 2'd3; a = 32'h0; b = 32'h0; ans = '0;
        repeat (3) tick();
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_sticky", flags_sticky, 4'h0);
        check("mid_rst_s", s, 32'h0);
        check("mid_rst_flags", flags, 4'h0);
        check("mid_rst_cnt", exc_cnt, 0);
        q.delete();
        sticky_m = '0;
        cnt_m    = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            tick();
            check("post_rst_valid", out_valid, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
